shade_mapper_pipe: RTL and testbench
====================================

SHADE_MAPPER_PIPE -- requirements
Module: shade_mapper_pipe

Interface
REQ-001 Parameter COLOR_W, default 8: width of one color channel.
REQ-002 Parameter FRAC_W, default 32: fractional bits of zcomp (Q32.32 fixed point).
REQ-003 Parameter NUM_BANDS, default 6, range 2..8: number of programmable shading bands.
REQ-004 Parameter CX, CY, defaults 320, 240: crosshair center. Parameter CROSS_HALF, default 3: crosshair arm length.
REQ-005 Parameter DITHER_STEP, default 8'h40: value added on dithered pixels.
REQ-006 Clk  in  1  single clock; all state updates on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1; in_ready  out  1: pixel input handshake, transfer when both high.
REQ-009 is_ball  in  1; zcomp  in  64 (Q32.32 angle, unsigned); DrawX, DrawY  in  10 each; colin  in  3*COLOR_W (ch2 = MSB).
REQ-010 frame_start  in  1: one-cycle pulse per frame.
REQ-011 dither_en, cross_en  in  1 each: mode enables, sampled with each accepted pixel.
REQ-012 cfg_we  in  1; cfg_sel  in  2 (0 = threshold, 1 = level, 2 = dither flag, 3 = ignored); cfg_idx  in  3; cfg_wdata  in  8.
REQ-013 out_valid  out  1; out_ready  in  1: output handshake, transfer when both high.
REQ-014 col  out  3*COLOR_W: shaded pixel color.

Function
REQ-015 The block SHALL be a 3-stage pipeline (S1 fold, S2 band lookup, S3 dither/crosshair); latency is exactly 3 cycles when out_ready stays high.
REQ-016 stall = out_valid & ~out_ready; in_ready SHALL equal ~stall; on stall all stages hold, including bubbles.
REQ-017 Bubbles SHALL propagate as valid = 0 and are not collapsed.
REQ-018 S1: a pixel is in-range iff 90<<32 < zcomp < 270<<32, strict on both bounds; f = (270<<32) - zcomp if zcomp > 180<<32, else zcomp - (90<<32); angle a = f[FRAC_W+7:FRAC_W].
REQ-019 S1 SHALL capture frame_phase, DrawX[0], DrawY[0], the crosshair hit, dither_en and cross_en alongside the pixel.
REQ-020 S2: band b = smallest i < NUM_BANDS with a < thr[i]; if none matches, shade = all ones and dithering is suppressed.
REQ-021 S2: shade = lvl[b]; the dither request = dth[b] & dither_en & (DrawX[0] ^ DrawY[0] ^ frame_phase).
REQ-022 S3: a dithered shade SHALL be shade + DITHER_STEP, saturating at 2^COLOR_W - 1.
REQ-023 Channel selection: is_ball = 1 gives col = colin unchanged; otherwise in-range gives col = {shade, shade, shade}; otherwise col = 0.
REQ-024 Crosshair hit SHALL be (DrawX == CX and |DrawY - CY| <= CROSS_HALF) or (DrawY == CY and |DrawX - CX| <= CROSS_HALF).
REQ-025 On a hit with cross_en = 1, S3 SHALL bitwise-invert all channels after dithering, and SHALL do so for ball pixels too.
REQ-026 frame_phase SHALL toggle on every frame_start pulse, regardless of stall.
REQ-027 A pixel accepted in the same cycle as a frame_start pulse SHALL sample the pre-toggle phase.
REQ-028 A cfg write with cfg_idx >= NUM_BANDS or cfg_sel = 3 SHALL be ignored.
REQ-029 Config writes SHALL take effect the next cycle and are not blocked by stall.
REQ-030 S2 uses the table value present in the cycle that pixel occupies S2; pixels already past S2 are unaffected.
REQ-031 Thresholds need not be monotonic; REQ-020 defines the result in all cases.
REQ-032 col and out_valid SHALL be driven directly from S3 registers.

Reset
REQ-033 On Reset: all stage valids = 0, out_valid = 0, col = 0 and frame_phase = 0.
REQ-034 On Reset: thr = {4,12,21,30,40,255,255,255}, lvl = {3F,7F,7F,BF,BF,FF,FF,FF}, dth = {1,0,1,0,1,0,0,0}, each indexed from 0.
REQ-035 Reset SHALL override stall, in-flight pixels and a simultaneous cfg_we; in_ready = 1 in the cycle after reset.

Verification
REQ-036 zcomp = 100<<32, X=10, Y=10, phase 0, dither_en=1 -> a=10, band 1, col = 7F7F7F exactly 3 cycles later.
REQ-037 zcomp = 92<<32, X=11, Y=10, dither_en=1 -> band 0 dithered, col = 7F7F7F; repeat with X=10 -> 3F3F3F; repeat after one frame_start with X=10 -> 7F7F7F.
REQ-038 zcomp = 90<<32 and zcomp = 270<<32 -> col = 000000; is_ball=1, colin = 123456, X=320, Y=243, cross_en=1 -> col = EDCBA9; same at Y=244 -> 123456.
REQ-039 Write lvl[5] = F0, dth[5] = 1, then zcomp = 130<<32 with dither active -> col = FFFFFF (saturated); write to cfg_idx = 7 with NUM_BANDS = 6 -> no effect.
REQ-040 Stream 5 pixels with out_ready low for cycles 4-6 -> in_ready low those cycles, no pixel lost or duplicated, output order preserved.
REQ-041 Assert Reset mid-stream with a stall active -> out_valid = 0 next cycle, tables back at defaults, no stale pixel emitted.

Source files
------------

// File: rtl/shade_mapper_pipe.sv
// shade_mapper_pipe: three-stage pixel shader.
//   S1 folds the Q32.32 angle into a band index angle and latches pixel context,
//   S2 looks the angle up in the programmable band tables,
//   S3 applies saturating dither, channel selection and crosshair inversion.
// A single stall term (output held and not accepted) freezes every stage.
module shade_mapper_pipe #(
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned FRAC_W      = 32,
    parameter int unsigned NUM_BANDS   = 6,
    parameter int unsigned CX          = 320,
    parameter int unsigned CY          = 240,
    parameter int unsigned CROSS_HALF  = 3,
    parameter int unsigned DITHER_STEP = 'h40
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   is_ball,
    input  logic [63:0]            zcomp,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [3*COLOR_W-1:0]   colin,
    input  logic                   frame_start,
    input  logic                   dither_en,
    input  logic                   cross_en,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [2:0]             cfg_idx,
    input  logic [7:0]             cfg_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3*COLOR_W-1:0]   col
);

    localparam logic [63:0] Z_LO  = 64'(90)  << FRAC_W;
    localparam logic [63:0] Z_MID = 64'(180) << FRAC_W;
    localparam logic [63:0] Z_HI  = 64'(270) << FRAC_W;
    localparam logic [COLOR_W:0] DSTEP = (COLOR_W+1)'(DITHER_STEP);

    localparam logic [7:0] THR_RST [8] = '{8'd4, 8'd12, 8'd21, 8'd30, 8'd40, 8'd255, 8'd255, 8'd255};
    localparam logic [7:0] LVL_RST [8] = '{8'h3F, 8'h7F, 8'h7F, 8'hBF, 8'hBF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic       DTH_RST [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Shared state
    logic                 w_stall;
    logic                 r_phase;
    logic [7:0]           r_thr [8];
    logic [7:0]           r_lvl [8];
    logic                 r_dth [8];

    // Stage 1 registers
    logic                 r_s1_valid;
    logic                 r_s1_ball;
    logic                 r_s1_inrange;
    logic [7:0]           r_s1_angle;
    logic [3*COLOR_W-1:0] r_s1_colin;
    logic                 r_s1_phase;
    logic                 r_s1_x0;
    logic                 r_s1_y0;
    logic                 r_s1_hit;
    logic                 r_s1_den;
    logic                 r_s1_cen;

    // Stage 2 registers
    logic                 r_s2_valid;
    logic                 r_s2_ball;
    logic                 r_s2_inrange;
    logic [COLOR_W-1:0]   r_s2_shade;
    logic                 r_s2_dreq;
    logic [3*COLOR_W-1:0] r_s2_colin;
    logic                 r_s2_hit;
    logic                 r_s2_cen;

    // Stage 3 registers
    logic                 r_s3_valid;
    logic [3*COLOR_W-1:0] r_col;

    // Combinational helpers
    logic                 w_inrange;
    logic [63:0]          w_fold;
    logic [7:0]           w_angle;
    logic signed [11:0]   w_dx, w_dy, w_adx, w_ady;
    logic                 w_hit;
    logic                 w_found;
    logic [COLOR_W-1:0]   w_shade;
    logic                 w_dth;
    logic [COLOR_W:0]     w_sum;
    logic [COLOR_W-1:0]   w_dshade;
    logic [3*COLOR_W-1:0] w_col;

    assign w_stall   = r_s3_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_s3_valid;
    assign col       = r_col;

    // S1 combinational: range test, angle fold and crosshair hit
    always_comb begin
        w_inrange = (zcomp > Z_LO) && (zcomp < Z_HI);
        w_fold    = (zcomp > Z_MID) ? (Z_HI - zcomp) : (zcomp - Z_LO);
        w_angle   = w_fold[FRAC_W+7:FRAC_W];
        w_dx      = $signed({2'b00, DrawX}) - $signed(12'(CX));
        w_dy      = $signed({2'b00, DrawY}) - $signed(12'(CY));
        w_adx     = w_dx[11] ? -w_dx : w_dx;
        w_ady     = w_dy[11] ? -w_dy : w_dy;
        w_hit     = ((DrawX == 10'(CX)) && (w_ady <= $signed(12'(CROSS_HALF)))) ||
                    ((DrawY == 10'(CY)) && (w_adx <= $signed(12'(CROSS_HALF))));
    end

    // Frame phase toggles on every frame_start, independent of stall
    always_ff @(posedge Clk) begin
        if (Reset)
            r_phase <= 1'b0;
        else if (frame_start)
            r_phase <= ~r_phase;
    end

    // Band tables: writes land next cycle, out-of-range index or sel 3 dropped
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_thr <= THR_RST;
            r_lvl <= LVL_RST;
            r_dth <= DTH_RST;
        end else if (cfg_we && (32'(cfg_idx) < NUM_BANDS)) begin
            case (cfg_sel)
                2'd0:    r_thr[cfg_idx] <= cfg_wdata;
                2'd1:    r_lvl[cfg_idx] <= cfg_wdata;
                2'd2:    r_dth[cfg_idx] <= cfg_wdata[0];
                default: ;
            endcase
        end
    end

    // S1 registers: accept a pixel (or a bubble) whenever not stalled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid   <= in_valid;
            r_s1_ball    <= is_ball;
            r_s1_inrange <= w_inrange;
            r_s1_angle   <= w_angle;
            r_s1_colin   <= colin;
            r_s1_phase   <= r_phase;
            r_s1_x0      <= DrawX[0];
            r_s1_y0      <= DrawY[0];
            r_s1_hit     <= w_hit;
            r_s1_den     <= dither_en;
            r_s1_cen     <= cross_en;
        end
    end

    // S2 combinational: first band whose threshold exceeds the angle wins
    always_comb begin
        w_found = 1'b0;
        w_shade = '1;
        w_dth   = 1'b0;
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            if (!w_found && (r_s1_angle < r_thr[i[2:0]])) begin
                w_found = 1'b1;
                w_shade = COLOR_W'(r_lvl[i[2:0]]);
                w_dth   = r_dth[i[2:0]];
            end
        end
    end

    // S2 registers: shade and dither request
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s2_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_ball    <= r_s1_ball;
            r_s2_inrange <= r_s1_inrange;
            r_s2_shade   <= w_shade;
            r_s2_dreq    <= w_found & w_dth & r_s1_den & (r_s1_x0 ^ r_s1_y0 ^ r_s1_phase);
            r_s2_colin   <= r_s1_colin;
            r_s2_hit     <= r_s1_hit;
            r_s2_cen     <= r_s1_cen;
        end
    end

    // S3 combinational: saturating dither, channel select, crosshair inversion
    always_comb begin
        w_sum    = {1'b0, r_s2_shade} + DSTEP;
        w_dshade = r_s2_shade;
        if (r_s2_dreq)
            w_dshade = w_sum[COLOR_W] ? '1 : w_sum[COLOR_W-1:0];
        if (r_s2_ball)
            w_col = r_s2_colin;
        else if (r_s2_inrange)
            w_col = {w_dshade, w_dshade, w_dshade};
        else
            w_col = '0;
        if (r_s2_hit && r_s2_cen)
            w_col = ~w_col;
    end

    // S3 registers drive the outputs directly
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s3_valid <= 1'b0;
            r_col      <= '0;
        end else if (!w_stall) begin
            r_s3_valid <= r_s2_valid;
            r_col      <= w_col;
        end
    end

endmodule

// File: tb/tb_shade_mapper_pipe.sv
// Directed bench for shade_mapper_pipe: vector table plus multi-cycle sequences.
module tb_shade_mapper_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_ball;
    logic [63:0] zcomp;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [23:0] colin;
    logic        frame_start;
    logic        dither_en;
    logic        cross_en;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [2:0]  cfg_idx;
    logic [7:0]  cfg_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] col;

    int total = 0;
    int bad   = 0;

    shade_mapper_pipe #(
        .COLOR_W(8), .FRAC_W(32), .NUM_BANDS(6), .CX(320), .CY(240),
        .CROSS_HALF(3), .DITHER_STEP('h40)
    ) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_ball(is_ball), .zcomp(zcomp), .DrawX(DrawX), .DrawY(DrawY),
        .colin(colin), .frame_start(frame_start), .dither_en(dither_en),
        .cross_en(cross_en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .out_valid(out_valid),
        .out_ready(out_ready), .col(col)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [63:0] z;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ball;
        logic [23:0] cin;
        logic        de;
        logic        ce;
        logic [23:0] exp;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input string n, input logic [63:0] z, input int x, input int y,
                                input logic ball, input logic [23:0] cin, input logic de,
                                input logic ce, input logic [23:0] exp);
        vec_t v;
        v.name = n; v.z = z; v.x = 10'(x); v.y = 10'(y); v.ball = ball;
        v.cin = cin; v.de = de; v.ce = ce; v.exp = exp;
        return v;
    endfunction

    function automatic logic [63:0] q(input int deg);
        return 64'(deg) << 32;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one pixel (optionally with a coincident frame_start) and check latency and color
    task automatic send(input vec_t v, input logic fs);
        int  cyc;
        bit  seen;
        @(negedge Clk);
        zcomp = v.z; DrawX = v.x; DrawY = v.y; is_ball = v.ball; colin = v.cin;
        dither_en = v.de; cross_en = v.ce; in_valid = 1'b1; frame_start = fs;
        cyc = 0; seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge Clk);
            in_valid = 1'b0; frame_start = 1'b0;
            cyc++;
            if (out_valid) seen = 1'b1;
        end
        chk({v.name, " latency"}, 64'(cyc), 64'd3);
        chk({v.name, " col"}, 64'(col), 64'(v.exp));
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [2:0] idx, input logic [7:0] d);
        @(negedge Clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_wdata = d;
        @(negedge Clk);
        cfg_we = 1'b0;
    endtask

    task automatic fs_pulse();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] got [$];
        int          k;
        bit          acc;
        bit          leaked;

        Reset = 1'b1; in_valid = 1'b0; is_ball = 1'b0; zcomp = '0; DrawX = '0; DrawY = '0;
        colin = '0; frame_start = 1'b0; dither_en = 1'b0; cross_en = 1'b0; cfg_we = 1'b0;
        cfg_sel = '0; cfg_idx = '0; cfg_wdata = '0; out_ready = 1'b1;

        vt[0]  = mk("z100_band1",     q(100),                 10,  10,  0, 24'h0,      1, 0, 24'h7F7F7F);
        vt[1]  = mk("z92_dither",     q(92),                  11,  10,  0, 24'h0,      1, 0, 24'h7F7F7F);
        vt[2]  = mk("z92_nodither",   q(92),                  10,  10,  0, 24'h0,      1, 0, 24'h3F3F3F);
        vt[3]  = mk("z90_out",        q(90),                  11,  10,  0, 24'h0,      1, 0, 24'h000000);
        vt[4]  = mk("z270_out",       q(270),                 11,  10,  0, 24'h0,      1, 0, 24'h000000);
        vt[5]  = mk("z90p_in",        q(90) + 64'd1,          10,  10,  0, 24'h0,      0, 0, 24'h3F3F3F);
        vt[6]  = mk("z270m_in",       q(270) - 64'd1,         10,  10,  0, 24'h0,      0, 0, 24'h3F3F3F);
        vt[7]  = mk("z200_band5",     q(200),                 10,  10,  0, 24'h0,      0, 0, 24'hFFFFFF);
        vt[8]  = mk("z260h_fold",     q(260) + 64'h80000000,  10,  10,  0, 24'h0,      0, 0, 24'h7F7F7F);
        vt[9]  = mk("z121_band4",     q(121),                 10,  10,  0, 24'h0,      1, 0, 24'hBFBFBF);
        vt[10] = mk("z110_band2_dth", q(110),                 11,  10,  0, 24'h0,      1, 0, 24'hBFBFBF);
        vt[11] = mk("ball_cross_in",  q(0),                   320, 243, 1, 24'h123456, 0, 1, 24'hEDCBA9);
        vt[12] = mk("ball_cross_out", q(0),                   320, 244, 1, 24'h123456, 0, 1, 24'h123456);
        vt[13] = mk("hor_arm_edge",   q(0),                   317, 240, 0, 24'h0,      0, 1, 24'hFFFFFF);
        vt[14] = mk("hor_arm_past",   q(0),                   316, 240, 0, 24'h0,      0, 1, 24'h000000);
        vt[15] = mk("ball_cross_off", q(0),                   320, 243, 1, 24'h123456, 0, 0, 24'h123456);
        vt[16] = mk("ball_inrange",   q(100),                 11,  10,  1, 24'hABCDEF, 1, 0, 24'hABCDEF);
        vt[17] = mk("shade_cross",    q(100),                 320, 237, 0, 24'h0,      0, 1, 24'h808080);

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset col", 64'(col), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        foreach (vt[i]) send(vt[i], 1'b0);

        // Frame phase: coincident pixel sees old phase, next pixel sees toggled phase
        send(mk("fs_same_cycle", q(92), 10, 10, 0, 24'h0, 1, 0, 24'h3F3F3F), 1'b1);
        send(mk("phase1_x10",    q(92), 10, 10, 0, 24'h0, 1, 0, 24'h7F7F7F), 1'b0);
        fs_pulse();
        send(mk("phase0_again",  q(92), 10, 10, 0, 24'h0, 1, 0, 24'h3F3F3F), 1'b0);

        // Table programming
        cfg(2'd1, 3'd5, 8'hF0);
        cfg(2'd2, 3'd5, 8'h01);
        send(mk("lvl5_sat",      q(130), 11, 10, 0, 24'h0, 1, 0, 24'hFFFFFF), 1'b0);
        send(mk("lvl5_plain",    q(130), 10, 10, 0, 24'h0, 1, 0, 24'hF0F0F0), 1'b0);
        cfg(2'd0, 3'd5, 8'h00);
        send(mk("no_band_match", q(130), 10, 10, 0, 24'h0, 0, 0, 24'hFFFFFF), 1'b0);
        cfg(2'd1, 3'd1, 8'h11);
        cfg(2'd3, 3'd1, 8'h00);
        cfg(2'd1, 3'd7, 8'h00);
        cfg(2'd1, 3'd6, 8'h00);
        send(mk("lvl1_ignored_wr", q(100), 10, 10, 0, 24'h0, 0, 0, 24'h111111), 1'b0);

        // Reset mid-stream with a stall and a coincident cfg write
        fs_pulse();
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            out_ready = 1'b0; in_valid = 1'b1; is_ball = 1'b1; colin = 24'hAAAAAA;
            cross_en = 1'b0;
        end
        #1;
        chk("stall before reset out_valid", 64'(out_valid), 64'd1);
        chk("stall before reset in_ready", 64'(in_ready), 64'd0);
        @(negedge Clk);
        Reset = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd1; cfg_idx = 3'd0; cfg_wdata = 8'h00;
        @(negedge Clk);
        Reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; is_ball = 1'b0;
        #1;
        chk("post reset out_valid", 64'(out_valid), 64'd0);
        chk("post reset in_ready", 64'(in_ready), 64'd1);
        chk("post reset col", 64'(col), 64'd0);
        out_ready = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (out_valid) leaked = 1'b1;
        end
        chk("no stale pixel", 64'(leaked), 64'd0);
        send(mk("rst_lvl0_phase", q(92), 10, 10, 0, 24'h0, 1, 0, 24'h3F3F3F), 1'b0);
        send(mk("rst_lvl1",       q(100), 10, 10, 0, 24'h0, 0, 0, 24'h7F7F7F), 1'b0);
        send(mk("rst_thr5_lvl5",  q(130), 11, 10, 0, 24'h0, 1, 0, 24'hFFFFFF), 1'b0);

        // Five-pixel stream with out_ready low in cycles 4..6
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            out_ready = !(c >= 4 && c <= 6);
            if (k < 5) begin
                in_valid = 1'b1; is_ball = 1'b1; cross_en = 1'b0;
                DrawX = '0; DrawY = '0; zcomp = '0;
                colin = {8'(8'h10 + k), 8'h20, 8'(8'h30 + k)};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) chk($sformatf("stream in_ready c%0d", c), 64'(in_ready),
                           64'(!(c >= 4 && c <= 6)));
            if (out_valid && out_ready) got.push_back(col);
            acc = in_valid && in_ready;
            @(posedge Clk);
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("stream count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("stream px%0d", i), 64'((i < got.size()) ? got[i] : 24'h0),
                64'({8'(8'h10 + i), 8'h20, 8'(8'h30 + i)}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
